// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage_pkg                                                      |
// | Shared processor constants: fetch FSM encoding and NOP/HALT opcodes. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_t;

    localparam logic [4:0]  c_OP_HALT  = 5'b00000;
    localparam logic [4:0]  c_OP_NOP   = 5'b00001;
    localparam logic [15:0] c_NOP_WORD = {c_OP_NOP, 11'd0};

endpackage
`default_nettype wire

// File: rtl/fetch_stage_pc_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage_pc_reg                                                   |
// | 16-bit program counter with load and increment-by-2 enables.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_stage_pc_reg #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    input  logic        i_inc,
    output logic [15:0] o_pc
);

    logic [15:0] r_pc;

    // Load wins over increment so a redirect is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + 16'd2;
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage                                                          |
// | Single-outstanding instruction fetch with redirect, stall and halt.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_WORD = c_NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_rdata,
    input  logic        stall_in,
    input  logic        redirect_en,
    input  logic [15:0] redirect_pc,
    input  logic        halt_in,
    output logic [15:0] instr_out,
    output logic [15:0] pc_out,
    output logic [15:0] pc_inc,
    output logic        instr_valid,
    output logic        halted
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [15:0]  w_pc;
    logic         w_pc_load;
    logic         w_pc_inc;
    logic         w_capture;
    logic         w_clear;
    logic         r_imem_req;
    logic         r_halted;
    logic         r_instr_valid;
    logic [15:0]  r_instr;
    logic [15:0]  r_pc_out;

    fetch_stage_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_pc_load),
        .i_load_val (redirect_pc & 16'hFFFE),
        .i_inc      (w_pc_inc),
        .o_pc       (w_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Halt only counts against a valid instruction; HALT is terminal until reset.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_load   = 1'b0;
        w_pc_inc    = 1'b0;
        w_capture   = 1'b0;
        w_clear     = 1'b0;
        if (r_state != ST_HALT) begin
            if (halt_in && r_instr_valid) begin
                w_state_nxt = ST_HALT;
                w_clear     = 1'b1;
            end else if (redirect_en) begin
                w_state_nxt = ST_IDLE;
                w_pc_load   = 1'b1;
                w_clear     = 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: w_state_nxt = ST_REQ;
                    ST_REQ: begin
                        if (imem_rdy) begin
                            w_state_nxt = ST_HOLD;
                            w_capture   = 1'b1;
                            w_pc_inc    = 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (!stall_in) begin
                            w_state_nxt = ST_REQ;
                            w_clear     = 1'b1;
                        end
                    end
                    default: w_state_nxt = r_state;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_imem_req    <= 1'b0;
            r_halted      <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= NOP_WORD;
            r_pc_out      <= RESET_PC;
        end else begin
            r_imem_req <= (w_state_nxt == ST_REQ);
            r_halted   <= (w_state_nxt == ST_HALT);
            if (w_capture) begin
                r_instr       <= imem_rdata;
                r_pc_out      <= w_pc;
                r_instr_valid <= 1'b1;
            end else if (w_clear) begin
                r_instr       <= NOP_WORD;
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = w_pc;
    assign instr_out   = r_instr;
    assign pc_out      = r_pc_out;
    assign pc_inc      = r_pc_out + 16'd2;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_stage                                                       |
// | Directed and random checks of fetch_stage against a reference model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fetch_stage;

    localparam logic [15:0] c_NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        stall_in = 1'b0;
    logic        redirect_en = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        halt_in = 1'b0;
    logic [15:0] instr_out;
    logic [15:0] pc_out;
    logic [15:0] pc_inc;
    logic        instr_valid;
    logic        halted;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: what the fetch unit has promised, not how it is built.
    logic [15:0] m_pc, m_instr, m_pcout;
    logic        m_req, m_gap, m_valid, m_halted;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdy    (imem_rdy),
        .imem_rdata  (imem_rdata),
        .stall_in    (stall_in),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt_in     (halt_in),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .pc_inc      (pc_inc),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = c_NOP; m_pcout = 16'h0000;
        m_req = 1'b0; m_gap = 1'b1; m_valid = 1'b0; m_halted = 1'b0;
    endtask

    task automatic model_step(input logic rdy, input logic [15:0] rdata, input logic stall,
                              input logic redir, input logic [15:0] rpc, input logic halt);
        if (m_halted) begin
            // terminal
        end else if (halt && m_valid) begin
            m_halted = 1'b1; m_valid = 1'b0; m_instr = c_NOP; m_req = 1'b0;
        end else if (redir) begin
            m_pc = {rpc[15:1], 1'b0}; m_valid = 1'b0; m_instr = c_NOP;
            m_req = 1'b0; m_gap = 1'b1;
        end else if (m_gap) begin
            m_gap = 1'b0; m_req = 1'b1;
        end else if (m_req) begin
            if (rdy) begin
                m_instr = rdata; m_pcout = m_pc; m_pc = m_pc + 16'd2;
                m_valid = 1'b1; m_req = 1'b0;
            end
        end else if (m_valid && !stall) begin
            m_valid = 1'b0; m_instr = c_NOP; m_req = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".req"},    {15'd0, imem_req},    {15'd0, m_req});
        chk({tag, ".addr"},   imem_addr,            m_pc);
        chk({tag, ".instr"},  instr_out,            m_instr);
        chk({tag, ".pc_out"}, pc_out,               m_pcout);
        chk({tag, ".pc_inc"}, pc_inc,               m_pcout + 16'd2);
        chk({tag, ".valid"},  {15'd0, instr_valid}, {15'd0, m_valid});
        chk({tag, ".halted"}, {15'd0, halted},      {15'd0, m_halted});
    endtask

    // One clock: check at the negedge, drive, advance model at the posedge.
    task automatic cyc(input string tag, input logic rdy, input logic [15:0] rdata,
                       input logic stall, input logic redir, input logic [15:0] rpc,
                       input logic halt);
        check_all(tag);
        imem_rdy = rdy; imem_rdata = rdata; stall_in = stall;
        redirect_en = redir; redirect_pc = rpc; halt_in = halt;
        @(posedge clk);
        model_step(rdy, rdata, stall, redir, rpc, halt);
        @(negedge clk);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        imem_rdy = 1'b0; stall_in = 1'b0; redirect_en = 1'b0; halt_in = 1'b0;
        #1 model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // Zero-wait fetch of 16'h4123 at address 0
        cyc("s1_idle", 1'b0, 16'h0,    1'b0, 1'b0, 16'h0, 1'b0);
        chk("s1_req_rise", {15'd0, imem_req}, 16'd1);
        cyc("s1_req",  1'b1, 16'h4123, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("s1_valid",  {15'd0, instr_valid}, 16'd1);
        chk("s1_instr",  instr_out, 16'h4123);
        chk("s1_pc_out", pc_out,    16'h0000);
        chk("s1_pc_inc", pc_inc,    16'h0002);
        cyc("s1_hold", 1'b0, 16'h0,    1'b0, 1'b0, 16'h0, 1'b0);
        chk("s1_next_addr", imem_addr, 16'h0002);

        // Stall three cycles in HOLD
        cyc("s2_req", 1'b1, 16'h5A5A, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc("s2_stall", 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
            chk("s2_stall_instr", instr_out, 16'h5A5A);
            chk("s2_stall_noreq", {15'd0, imem_req}, 16'd0);
        end
        cyc("s2_release", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("s2_next_addr", imem_addr, 16'h0004);

        // Redirect in REQ with a colliding response
        cyc("s3_redir", 1'b1, 16'hDEAD, 1'b0, 1'b1, 16'h0041, 1'b0);
        chk("s3_discard", {15'd0, instr_valid}, 16'd0);
        chk("s3_gap", {15'd0, imem_req}, 16'd0);
        cyc("s3_idle", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("s3_target", imem_addr, 16'h0040);

        // Three wait states
        for (int i = 0; i < 3; i++)
            cyc("s4_wait", 1'b0, 16'hBAD0, 1'b0, 1'b0, 16'h0, 1'b0);
        cyc("s4_rdy",  1'b1, 16'h1357, 1'b0, 1'b0, 16'h0, 1'b0);
        cyc("s4_hold", 1'b0, 16'h0,    1'b0, 1'b0, 16'h0, 1'b0);
        cyc("s4_req",  1'b0, 16'h0,    1'b0, 1'b0, 16'h0, 1'b0);

        // Halt beats a same-cycle redirect
        cyc("s5_req",  1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0);
        cyc("s5_halt", 1'b0, 16'h0,    1'b1, 1'b1, 16'h1234, 1'b1);
        for (int i = 0; i < 4; i++)
            cyc("s5_halted", 1'b1, 16'h0, 1'b0, 1'b1, 16'h2000, 1'b1);
        chk("s5_halted_flag", {15'd0, halted}, 16'd1);
        chk("s5_pc_kept", imem_addr, 16'h0044);
        async_reset("s5_arst");
        cyc("s5b_idle", 1'b0, 16'h0,    1'b0, 1'b0, 16'h0, 1'b0);
        cyc("s5b_req",  1'b1, 16'h4123, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("s5b_instr", instr_out, 16'h4123);
        chk("s5b_pc_inc", pc_inc, 16'h0002);

        // PC wrap
        cyc("s6_redir", 1'b0, 16'h0,    1'b0, 1'b1, 16'hFFFF, 1'b0);
        cyc("s6_idle",  1'b0, 16'h0,    1'b0, 1'b0, 16'h0, 1'b0);
        chk("s6_addr", imem_addr, 16'hFFFE);
        cyc("s6_req",   1'b1, 16'h7777, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("s6_pc_inc", pc_inc, 16'h0000);
        cyc("s6_hold",  1'b0, 16'h0,    1'b0, 1'b0, 16'h0, 1'b0);
        chk("s6_wrap_addr", imem_addr, 16'h0000);

        // Mid-operation async reset while holding
        cyc("s7_req", 1'b1, 16'h2468, 1'b1, 1'b0, 16'h0, 1'b0);
        async_reset("s7_arst");

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] rpc;
            rpc = (($urandom % 8) == 0) ? 16'hFFFE : 16'($urandom);
            cyc("rnd",
                ($urandom % 2) == 0,
                16'($urandom),
                ($urandom % 10) < 3,
                ($urandom % 20) == 0,
                rpc,
                ($urandom % 60) == 0);
            if (m_halted && ($urandom % 8) == 0)
                async_reset("rnd_arst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the 16-bit processor. It holds the program counter and issues one request at a time to instruction memory. It presents the fetched word, with its PC and PC+2, to the control/decode stage. It also handles redirects from branch/jump resolution, back-pressure from downstream, and the sticky halt condition that decode raises when it sees HALT.

## Interface
Parameters:
- RESET_PC, 16'h0000: PC value loaded on reset.
- NOP_WORD, 16'h0800: word driven on instr_out whenever no valid instruction is held (opcode 00001, NOP).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  request strobe, held high until imem_rdy.
- imem_addr  out  16  byte address of the request; equals pc while imem_req is high.
- imem_rdy  in  1  memory response valid; imem_rdata is sampled on this cycle.
- imem_rdata  in  16  instruction word.
- stall_in  in  1  downstream not accepting this cycle.
- redirect_en  in  1  taken branch/jump; load redirect_pc.
- redirect_pc  in  16  target address; bit 0 is ignored and forced to 0.
- halt_in  in  1  decode saw HALT on the current instr_out.
- instr_out  out  16  instruction to decode.
- pc_out  out  16  address of instr_out.
- pc_inc  out  16  pc_out + 2, mod 2^16 (used for JAL/JALR link).
- instr_valid  out  1  instr_out/pc_out are valid.
- halted  out  1  fetch permanently stopped.

## Operation
- State is 16-bit pc plus an FSM with states IDLE, REQ, HOLD and HALT.
- IDLE: no request is issued. The FSM moves to REQ on the next cycle.
- REQ: imem_req=1 and imem_addr=pc. On imem_rdy:
  - capture imem_rdata into instr_out and pc into pc_out;
  - pc<=pc+2 (wraps 16'hFFFE→16'h0000);
  - instr_valid<=1;
  - go to HOLD.
- HOLD: instr_out is held stable while stall_in=1. If stall_in=0, the instruction is accepted that cycle, then instr_valid<=0, instr_out<=NOP_WORD and the FSM goes to REQ.
- HALT: entered when halt_in=1 is seen while instr_valid=1. The FSM then holds:
  - halted=1, imem_req=0, instr_valid=0;
  - pc keeps the address of the HALT instruction + 2.
  - It leaves HALT only on rst.
  - halt_in with instr_valid=0 is ignored.
- Redirect is accepted in IDLE, REQ and HOLD:
  - pc<={redirect_pc[15:1],1'b0}, instr_valid<=0, instr_out<=NOP_WORD, next state IDLE.
  - Any response arriving on the same cycle (imem_rdy=1) is discarded.
  - IDLE guarantees one cycle with imem_req=0, so the memory drops the abandoned access.
- Priority, same cycle, highest first: rst > halt_in (when valid) > redirect_en > imem_rdy / stall_in.
- A redirect in HOLD with stall_in=1 still squashes the held instruction.

## Timing
- Reset values:
  - pc=RESET_PC, state=IDLE;
  - imem_req=0, imem_addr=RESET_PC;
  - instr_out=NOP_WORD, pc_out=RESET_PC, pc_inc=RESET_PC+2;
  - instr_valid=0, halted=0.
- The first imem_req rises in the 2nd cycle after rst deasserts (IDLE→REQ).
- Latency:
  - With a zero-wait memory (rdy in the same cycle as req), instr_valid rises 1 cycle after the request cycle.
  - Best-case throughput is one instruction every 2 cycles.
- All outputs are registered except imem_addr, which is pc, and pc_inc, which is pc_out+2 and combinational.
- rst asserted mid-operation (in REQ, HOLD or HALT) returns all state to reset values asynchronously, with no residual request.
- redirect_en is a single-cycle pulse. Holding it high re-applies the redirect every cycle, and the FSM stays in IDLE.

## Structure
- The shared processor package holds the FSM state encoding (2-bit enum), NOP_WORD, and the HALT/NOP opcode constants (5'b00000 / 5'b00001) that are also used by the control decoder.
- One sub-module, pc_reg: a 16-bit async-reset register with load/increment-by-2 enable, shared with later pipelined fetch.

## Test plan
- Reset, then memory returning 16'h4123 at address 0 with rdy in the same cycle:
  - instr_valid=1 with instr_out=16'h4123, pc_out=0, pc_inc=2 on the 3rd cycle after reset;
  - the next imem_addr is 2.
- stall_in held for 3 cycles in HOLD: instr_out, pc_out and instr_valid are unchanged for all 3 cycles and imem_req=0. After release, the next request goes to the prior pc+2.
- redirect_en with redirect_pc=16'h0041 while in REQ and imem_rdy=1 on the same cycle:
  - the response is discarded and instr_valid stays 0;
  - imem_req=0 for one cycle, then a request is issued at 16'h0040.
- Memory with 3 wait cycles: imem_req stays high and imem_addr stays constant for 4 cycles. The instruction is delivered once, with no duplicate.
- halt_in asserted while instr_valid=1 and redirect_en=1 on the same cycle:
  - halt wins: halted=1, imem_req=0 permanently, and the redirect is ignored;
  - after rst, the block behaves as in the first scenario.
- PC wrap: redirect to 16'hFFFE, then fetch; the following request goes to 16'h0000 and pc_inc shows 16'h0000.
